// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

   localparam int unsigned CNT_W            = 8;
   localparam int unsigned PERF_W           = 32;
   localparam int unsigned TIMEOUT_DEF      = 255;
   localparam int unsigned DRAIN_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Wrapping performance counters for load-use stalls, taken-branch flushes and frozen cycles.
module hazard_perf_cnt
   import hazard_ctrl_pkg::*;
(
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic              lu_evt,
   input  logic              br_evt,
   input  logic              wait_evt,
   output logic [PERF_W-1:0] perf_lu_cnt,
   output logic [PERF_W-1:0] perf_br_cnt,
   output logic [PERF_W-1:0] perf_wait_cnt
);

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         perf_lu_cnt   <= '0;
         perf_br_cnt   <= '0;
         perf_wait_cnt <= '0;
      end else begin
         if (lu_evt)   perf_lu_cnt   <= perf_lu_cnt + PERF_W'(1);
         if (br_evt)   perf_br_cnt   <= perf_br_cnt + PERF_W'(1);
         if (wait_evt) perf_wait_cnt <= perf_wait_cnt + PERF_W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/halt sequencer with data-memory wait timeout.
// Perf counters are built only when HAZARD_CTRL_PERF_CNT_EN is defined.
//
// state       | meaning
// ST_RUN      | normal issue; resolves load-use, branch, halt request, memory freeze
// ST_MEM_WAIT | pipeline frozen until dmem_ack or timeout
// ST_DRAIN    | PC held, bubbles injected until the back end is empty
// ST_HALTED   | drained; halt_ack high until halt_req drops
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic              load_use,
   input  logic              br_taken_ex,
   input  logic              dmem_req,
   input  logic              dmem_ack,
   input  logic              halt_req,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_stall,
   output logic              exmem_stall,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              memwb_flush,
   output logic              halt_ack,
   output logic              mem_abort,
   output logic              bus_err,
   output logic [PERF_W-1:0] perf_lu_cnt,
   output logic [PERF_W-1:0] perf_br_cnt,
   output logic [PERF_W-1:0] perf_wait_cnt
);

   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   WAIT_LOAD  = CNT_W'(TIMEOUT - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   hz_state_e          state_q, state_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               bus_err_q;
   logic               freeze;

   assign freeze  = dmem_req & ~dmem_ack;
   assign bus_err = bus_err_q;

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         drain_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         drain_q   <= drain_d;
         bus_err_q <= bus_err_q | mem_abort;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      drain_d     = drain_q;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      halt_ack    = 1'b0;
      mem_abort   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (freeze) begin
               {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush} = '1;
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_LOAD;
            end else if (br_taken_ex) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else begin
               if (load_use) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
               end
               if (halt_req) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
         end
         ST_MEM_WAIT: begin
            // an ack on the terminal cycle wins over the timeout
            if (dmem_ack) begin
               state_d = ST_RUN;
            end else begin
               {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush} = '1;
               if (wait_q == '0) begin
                  mem_abort = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  wait_d = wait_q - CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (freeze) begin
               {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush} = '1;
            end else if (br_taken_ex) begin
               // PC released so the redirect lands; drain restarts behind it
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               drain_d    = DRAIN_LOAD;
            end else begin
               pc_stall   = 1'b1;
               ifid_flush = 1'b1;
               if (drain_q == '0) state_d = ST_HALTED;
               else               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         ST_HALTED: begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            halt_ack   = 1'b1;
            if (!halt_req) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      if (!cpu_rst_n) begin
         {pc_stall, ifid_stall, idex_stall, exmem_stall} = '0;
         {ifid_flush, idex_flush, memwb_flush}           = '0;
         halt_ack  = 1'b0;
         mem_abort = 1'b0;
      end
   end

`ifdef HAZARD_CTRL_PERF_CNT_EN
   logic lu_evt, br_evt, wait_evt;

   // only a load-use stall holds IF/ID without EX/MEM; only a taken branch flushes both
   assign lu_evt   = ifid_stall & ~exmem_stall;
   assign br_evt   = ifid_flush & idex_flush;
   assign wait_evt = exmem_stall;

   hazard_perf_cnt u_perf_cnt (
      .cpu_clk       (cpu_clk),
      .cpu_rst_n     (cpu_rst_n),
      .lu_evt        (lu_evt),
      .br_evt        (br_evt),
      .wait_evt      (wait_evt),
      .perf_lu_cnt   (perf_lu_cnt),
      .perf_br_cnt   (perf_br_cnt),
      .perf_wait_cnt (perf_wait_cnt)
   );
`else
   assign perf_lu_cnt   = '0;
   assign perf_br_cnt   = '0;
   assign perf_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (TIMEOUT=4, DRAIN_CYCLES=4).
module tb_hazard_ctrl;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        load_use = 1'b0, br_taken_ex = 1'b0, dmem_req = 1'b0;
   logic        dmem_ack = 1'b0, halt_req = 1'b0;
   logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic        ifid_flush, idex_flush, memwb_flush, halt_ack, mem_abort, bus_err;
   logic [31:0] perf_lu_cnt, perf_br_cnt, perf_wait_cnt;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string      tag;
      logic [9:0] exp;
   } sb_t;
   sb_t sb_q[$];

   localparam logic [9:0] PS = 10'h200, IS = 10'h100, XS = 10'h080, MS = 10'h040;
   localparam logic [9:0] FI = 10'h020, FX = 10'h010, FW = 10'h008;
   localparam logic [9:0] HA = 10'h004, AB = 10'h002, BE = 10'h001;
   localparam logic [9:0] FRZ = PS | IS | XS | MS | FW;

   logic [9:0] obs;
   assign obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
                 idex_flush, memwb_flush, halt_ack, mem_abort, bus_err};

   always #5 cpu_clk = ~cpu_clk;

   hazard_ctrl #(.TIMEOUT(4), .DRAIN_CYCLES(4)) dut (
      .cpu_clk       (cpu_clk),
      .cpu_rst_n     (cpu_rst_n),
      .load_use      (load_use),
      .br_taken_ex   (br_taken_ex),
      .dmem_req      (dmem_req),
      .dmem_ack      (dmem_ack),
      .halt_req      (halt_req),
      .pc_stall      (pc_stall),
      .ifid_stall    (ifid_stall),
      .idex_stall    (idex_stall),
      .exmem_stall   (exmem_stall),
      .ifid_flush    (ifid_flush),
      .idex_flush    (idex_flush),
      .memwb_flush   (memwb_flush),
      .halt_ack      (halt_ack),
      .mem_abort     (mem_abort),
      .bus_err       (bus_err),
      .perf_lu_cnt   (perf_lu_cnt),
      .perf_br_cnt   (perf_br_cnt),
      .perf_wait_cnt (perf_wait_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs after the falling edge, log the expectation, compare before the rising edge.
   task automatic step(input string tag, input logic rst, input logic lu, input logic br,
                       input logic rq, input logic ak, input logic hr, input logic [9:0] exp);
      sb_t e;
      @(negedge cpu_clk);
      cpu_rst_n   = rst;
      load_use    = lu;
      br_taken_ex = br;
      dmem_req    = rq;
      dmem_ack    = ak;
      halt_req    = hr;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      #2;
      chk("sb_depth", 32'(sb_q.size()), 32'd1);
      e = sb_q.pop_front();
      chk(e.tag, {22'b0, obs}, {22'b0, e.exp});
   endtask

   task automatic perf_chk(input int lu, input int br, input int wt);
      int e_lu, e_br, e_wt;
`ifdef HAZARD_CTRL_PERF_CNT_EN
      e_lu = lu; e_br = br; e_wt = wt;
`else
      e_lu = lu * 0; e_br = br * 0; e_wt = wt * 0;
`endif
      chk("perf_lu", perf_lu_cnt, 32'(e_lu));
      chk("perf_br", perf_br_cnt, 32'(e_br));
      chk("perf_wait", perf_wait_cnt, 32'(e_wt));
   endtask

   initial begin
      // reset dominates every input
      step("rst0", 0, 1, 1, 1, 0, 1, 10'h0);
      step("rst1", 0, 1, 1, 1, 0, 1, 10'h0);
      step("idle", 1, 0, 0, 0, 0, 0, 10'h0);
      perf_chk(0, 0, 0);

      step("lu",       1, 1, 0, 0, 0, 0, PS | IS | FX);
      step("lu_after", 1, 0, 0, 0, 0, 0, 10'h0);
      perf_chk(1, 0, 0);

      step("lu_br",       1, 1, 1, 0, 0, 0, FI | FX);
      step("lu_br_after", 1, 0, 0, 0, 0, 0, 10'h0);
      perf_chk(1, 1, 0);

      // three frozen cycles then ack; hazards during freeze are ignored
      step("frz1",   1, 0, 0, 1, 0, 0, FRZ);
      step("frz2",   1, 1, 1, 1, 0, 1, FRZ);
      step("frz3",   1, 0, 0, 1, 0, 0, FRZ);
      step("frz_ack", 1, 0, 0, 1, 1, 0, 10'h0);
      step("frz_run", 1, 0, 0, 0, 0, 0, 10'h0);
      perf_chk(1, 1, 3);

      // no ack: abort on the fifth frozen cycle
      step("to1", 1, 0, 0, 1, 0, 0, FRZ);
      step("to2", 1, 0, 0, 1, 0, 0, FRZ);
      step("to3", 1, 0, 0, 1, 0, 0, FRZ);
      step("to4", 1, 0, 0, 1, 0, 0, FRZ);
      step("to5_abort", 1, 0, 0, 1, 0, 0, FRZ | AB);
      step("to_run",    1, 0, 0, 0, 0, 0, BE);
      step("to_lu",     1, 1, 0, 0, 0, 0, PS | IS | FX | BE);
      perf_chk(2, 1, 8);

      // ack on the terminal cycle beats the timeout
      step("tb1", 1, 0, 0, 1, 0, 0, FRZ | BE);
      step("tb2", 1, 0, 0, 1, 0, 0, FRZ | BE);
      step("tb3", 1, 0, 0, 1, 0, 0, FRZ | BE);
      step("tb4", 1, 0, 0, 1, 0, 0, FRZ | BE);
      step("tb5_ack",  1, 0, 0, 1, 1, 0, BE);
      step("tb_after", 1, 0, 0, 0, 0, 0, BE);
      perf_chk(2, 1, 12);

      // reset clears bus_err and counters
      step("rst_be",   0, 0, 0, 0, 0, 0, BE);
      step("post_rst", 1, 0, 0, 0, 0, 0, 10'h0);
      perf_chk(0, 0, 0);

      // plain halt: 4 drain cycles, halted, release
      step("h_req", 1, 0, 0, 0, 0, 1, 10'h0);
      for (int i = 0; i < 4; i++) step("h_drain", 1, 0, 0, 0, 0, 1, PS | FI);
      step("h_halt",  1, 0, 0, 0, 0, 1, PS | FI | HA);
      step("h_halt2", 1, 0, 0, 0, 0, 1, PS | FI | HA);
      step("h_drop",  1, 0, 0, 0, 0, 0, PS | FI | HA);
      step("h_run",   1, 0, 0, 0, 0, 0, 10'h0);

      // halt with load-use, branch restarting the drain, freeze holding it
      step("hl_req", 1, 1, 0, 0, 0, 1, PS | IS | FX);
      step("hl_d0",  1, 0, 0, 0, 0, 1, PS | FI);
      step("hl_br",  1, 0, 1, 0, 0, 1, FI | FX);
      step("hl_d1",  1, 0, 0, 0, 0, 1, PS | FI);
      step("hl_frz", 1, 0, 0, 1, 0, 1, FRZ);
      step("hl_d2",  1, 0, 0, 0, 0, 1, PS | FI);
      step("hl_d3",  1, 0, 0, 0, 0, 1, PS | FI);
      step("hl_d4",  1, 0, 0, 0, 0, 1, PS | FI);
      step("hl_halt", 1, 0, 0, 0, 0, 1, PS | FI | HA);
      step("hl_drop", 1, 0, 0, 0, 0, 0, PS | FI | HA);
      step("hl_run",  1, 0, 0, 0, 0, 0, 10'h0);
      perf_chk(1, 1, 1);

      // reset in the middle of a drain
      step("md_req",  1, 0, 0, 0, 0, 1, 10'h0);
      step("md_d0",   1, 0, 0, 0, 0, 1, PS | FI);
      step("md_d1",   1, 0, 0, 0, 0, 1, PS | FI);
      step("md_rst",  0, 1, 0, 0, 0, 1, 10'h0);
      step("md_post", 1, 0, 0, 0, 0, 0, 10'h0);
      step("md_lu",   1, 1, 0, 0, 0, 0, PS | IS | FX);
      step("md_idle", 1, 0, 0, 0, 0, 0, 10'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255 (8-bit): MEM_WAIT cycles before a bus error is declared.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: bubble cycles needed to empty the ID, EX, MEM and WB stages.
REQ-003 SHALL have ports, one clock, reset synchronous active-low:
- cpu_clk  in  1  clock
- cpu_rst_n  in  1  synchronous active-low reset
- load_use  in  1  load-use hazard flag from the data hazard detector
- br_taken_ex  in  1  branch/jump resolved taken in EX
- dmem_req  in  1  MEM stage issuing a data-memory access
- dmem_ack  in  1  data-memory access completes this cycle
- halt_req  in  1  debug halt request (level)
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold register
- ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble
- halt_ack  out  1  pipeline drained and halted
- mem_abort  out  1  one-cycle pulse: access abandoned
- bus_err  out  1  sticky timeout flag
- perf_lu_cnt, perf_br_cnt, perf_wait_cnt  out  32 each  performance counters

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED; outputs are Mealy: registered state plus current inputs.
REQ-005 SHALL define freeze = dmem_req & ~dmem_ack.
- In RUN, freeze asserts pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush that cycle.
- Next state is MEM_WAIT.
REQ-006 SHALL keep the freeze outputs asserted in MEM_WAIT while dmem_ack=0.
- When dmem_ack=1, all stalls deassert that cycle and the next state is RUN.
REQ-007 SHALL ignore load_use, br_taken_ex and halt_req in any cycle where freeze applies.
REQ-008 SHALL act on br_taken_ex=1 in RUN without freeze:
- assert ifid_flush and idex_flush
- no stall
- load_use is ignored that cycle (branch has priority).
REQ-009 SHALL act on load_use=1 (br_taken_ex=0) in RUN without freeze:
- assert pc_stall, ifid_stall and idex_flush for exactly that cycle.
REQ-010 SHALL act on halt_req=1 in RUN without freeze or branch:
- enter DRAIN next cycle with drain counter cleared to 0
- a load_use in the same cycle is still handled per REQ-009.
REQ-011 SHALL, in DRAIN, assert pc_stall and ifid_flush and increment the counter each unfrozen cycle.
- When counter = DRAIN_CYCLES-1, the next state is HALTED.
- Freeze holds the counter and applies REQ-005 outputs.
REQ-012 SHALL handle br_taken_ex=1 in DRAIN as follows:
- deassert pc_stall that cycle so the redirect loads
- assert ifid_flush and idex_flush
- reset the counter to 0.
REQ-013 SHALL, in HALTED, assert pc_stall, ifid_flush and halt_ack.
- When halt_req=0, the next state is RUN with halt_ack low from that next cycle.
REQ-014 SHALL count MEM_WAIT cycles in an 8-bit counter, cleared on MEM_WAIT entry.
- When the counter reaches TIMEOUT with dmem_ack=0, pulse mem_abort for one cycle, set bus_err and go to RUN.
REQ-015 SHALL give dmem_ack priority over timeout when both occur on the same cycle: no abort.
REQ-016 SHALL keep bus_err set until reset; the pipeline continues operating after it is set.

Reset
REQ-017 SHALL, on cpu_clk edge with cpu_rst_n=0, set state RUN, clear all counters, and clear bus_err and mem_abort.
REQ-018 SHALL hold all stall, flush and halt_ack outputs at 0 while cpu_rst_n=0, regardless of other inputs.
REQ-019 SHALL abandon any DRAIN, HALTED or MEM_WAIT state on reset with no mem_abort pulse.

Configuration
REQ-020 SHALL, with HAZARD_CTRL_PERF_CNT_EN defined, run wrapping 32-bit counters:
- perf_lu_cnt increments per REQ-009 stall cycle
- perf_br_cnt increments per taken-branch flush
- perf_wait_cnt increments per frozen cycle.
REQ-021 SHALL, without HAZARD_CTRL_PERF_CNT_EN, tie the perf outputs to 0 and synthesise no counter logic.

Structure
REQ-022 SHALL place the state enum, the DRAIN_CYCLES/TIMEOUT defaults and the counter width in package hazard_ctrl_pkg.
REQ-023 SHALL place the counters in a single sub-module, hazard_perf_cnt, instantiated only under the macro.

Verification
REQ-024 SHALL cover these directed scenarios:
- load_use=1 for 1 cycle in RUN -> pc_stall=ifid_stall=idex_flush=1 that cycle only; perf_lu_cnt=1.
- load_use=1 and br_taken_ex=1 together -> ifid_flush=idex_flush=1, pc_stall=0.
- dmem_req=1, dmem_ack after 3 cycles -> 3 frozen cycles with memwb_flush=1, then RUN; perf_wait_cnt=3.
- dmem_req=1, no ack, TIMEOUT=4 -> mem_abort pulses on the 5th frozen cycle, bus_err stays 1, state RUN.
- halt_req=1 held -> 4 DRAIN cycles, then halt_ack=1; drop halt_req -> RUN, halt_ack=0 next cycle.
- cpu_rst_n=0 mid-DRAIN -> all outputs 0, state RUN, no halt_ack.
